seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
Time-multiplexed scanner for a multi-digit common-anode seven-segment display.
- Holds a NUM_DIGITS x 4-bit display value and steps through the digits one refresh slot at a time.
- Presents the selected nibble to the hex-to-seven-segment decoder (nibble_out[3:0] maps to decoder inputs w,x,y,z, MSB first) and drives the matching digit enable.
- Takes new values on a load strobe, applies them only at frame boundaries (no tearing), inserts anti-ghosting guard cycles, and can suppress leading zeros.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be >= 1.
REFRESH_DIV, 50000, clock cycles per digit slot; must be > GUARD_CYCLES.
GUARD_CYCLES, 2, cycles at the start of each slot with all digits off; may be 0.
DIGIT_ACTIVE_LOW, 1, 1 = digit_sel enable is 0, 0 = enable is 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  one-cycle strobe; capture value_in
value_in  in  4*NUM_DIGITS  packed nibbles; digit i = value_in[4i+3:4i], digit 0 rightmost
lz_en  in  1  leading-zero suppression enable; level-sampled every cycle
nibble_out  out  4  nibble of the currently scanned digit, to the decoder
digit_sel  out  NUM_DIGITS  one-hot digit enable, polarity per DIGIT_ACTIVE_LOW
frame_start  out  1  one-cycle pulse in the first cycle of digit-0 slot

Behaviour:
State:
- Slot counter cnt: 0..REFRESH_DIV-1.
- Digit index idx: 0..NUM_DIGITS-1.
- Registers disp and pend (4*NUM_DIGITS each) and flag pend_v.
- Widths use $clog2, minimum 1 bit.

Scanning:
- Each cycle cnt increments. When cnt == REFRESH_DIV-1, cnt <= 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Frame length = NUM_DIGITS*REFRESH_DIV cycles.

Load and transfer:
- load asserted: pend <= value_in, pend_v <= 1. Several loads in one frame: last one wins.
- Transfer cycle = the cycle in which idx wraps to 0, or at NUM_DIGITS=1 every slot end.
  - If load is asserted in the transfer cycle: disp <= value_in directly, pend_v <= 0.
  - Else if pend_v: disp <= pend, pend_v <= 0.
  - Else disp holds.
- frame_start is a register set in the transfer cycle, so it is high during cnt==0 of the digit-0 slot.

Outputs:
- nibble_out and digit_sel are decoded only from registered state (cnt, idx, disp, lz_q). There is no combinational path from any input to any output.
- lz_q = lz_en registered.
- nibble_out = disp[4*idx +: 4].
- digit_sel enables only bit idx, and only when both hold:
  - cnt >= GUARD_CYCLES;
  - the digit is not blanked.
- Otherwise all bits are inactive.

Leading-zero suppression:
- Digit i (i > 0) is blanked when lz_q = 1 and disp digits NUM_DIGITS-1 down to i are all 0.
- Digit 0 is never blanked.

Reset, asynchronous, and mid-operation:
- cnt=0, idx=0, disp=0, pend=0, pend_v=0, lz_q=0, frame_start=0.
- Therefore nibble_out=0 and digit_sel all inactive when GUARD_CYCLES>0. With GUARD_CYCLES=0, digit 0 is enabled.
- After release, scanning restarts at digit 0.
- A pending load is lost.

Decomposition:
- Shared package seg_pkg:
  - NIBBLE_W = 4.
  - Function digit_sel_onehot(idx, en, active_low).
- Sub-module seg_refresh_prescaler (parameter DIV): cnt register plus slot_end tick output. The digit index, load path and blanking logic stay in the top.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, DIGIT_ACTIVE_LOW=1.
1. Assert rst mid-slot while digit 2 is shown.
   -> Same cycle: digit_sel=4'b1111, nibble_out=0, frame_start=0.
   -> After release: frame_start first pulses 16 cycles later, then every 16 cycles.
2. Load 16'h1234 while idx=2.
   -> Digits 2 and 3 keep the old value.
   -> From the next frame_start: slot 0 shows nibble 4 with digit_sel=1110 on cnt 1..3, and digit_sel=1111 on cnt 0. Slots 1/2/3 show 3/2/1 with sel 1101/1011/0111.
3. Two loads in one frame (16'hAAAA, then 16'h5555).
   -> Next frame displays 5555; AAAA is never displayed.
4. load 16'hBEEF asserted in the transfer cycle.
   -> Digit 0 of the new frame already shows F.
5. lz_en=1, value 16'h0070.
   -> Digits 3 and 2 stay 1111 for the whole slot.
   -> Digit 1 shows 7 and digit 0 shows 0.
6. lz_en=1, value 16'h0000.
   -> Only the digit 0 slot enables (1110), with nibble_out=0.
   -> lz_en=0 restores all four digits from the second cycle after the change.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants and digit-enable helper for the seven-segment
//            scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Width of one displayed digit (hex nibble).
    localparam int NIBBLE_W   = 4;
    // Upper bound on digits the enable helper can produce.
    localparam int MAX_DIGITS = 32;
    localparam int SEL_IDX_W  = $clog2(MAX_DIGITS);

    // One-hot digit enable for the scanned digit, all-inactive when en is low,
    // polarity flipped for common-anode drivers that enable on a low level.
    // Callers truncate the result to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] digit_sel_onehot(
        input logic [SEL_IDX_W-1:0] idx,
        input logic                 en,
        input logic                 active_low
    );
        logic [MAX_DIGITS-1:0] sel;
        sel = en ? (MAX_DIGITS'(1) << idx) : '0;
        return active_low ? ~sel : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_refresh_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : seg_refresh_prescaler
// Brief    : Counts clock cycles within one digit slot and flags the last one.
// Revision : 1.0 - initial release
// ============================================================================
module seg_refresh_prescaler #(
    parameter  int DIV   = 4,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             slot_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end = (cnt_q == CNT_W'(DIV - 1));
    assign cnt      = cnt_q;

    // Next count: wrap to zero at the end of the slot.
    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end

    // Slot counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed common-anode seven-segment scanner with
//            frame-aligned loads, guard cycles and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int GUARD_CYCLES     = 2,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
    input  logic                           lz_en,
    output logic [NIBBLE_W-1:0]            nibble_out,
    output logic [NUM_DIGITS-1:0]          digit_sel,
    output logic                           frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt;
    logic                  slot_end;
    logic                  last_digit;
    logic                  transfer;
    logic                  guard_done;
    logic                  digit_en;
    logic                  cur_blank;
    logic [NIBBLE_W-1:0]   cur_nibble;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zeros_above;

    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [VAL_W-1:0] disp_q,        disp_d;
    logic [VAL_W-1:0] pend_q,        pend_d;
    logic             pend_v_q,      pend_v_d;
    logic             lz_q,          lz_d;
    logic             frame_start_q, frame_start_d;

    seg_refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .slot_end (slot_end)
    );

    // The frame ends when the last digit's slot ends; with a single digit
    // that is every slot end.
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign transfer   = slot_end & last_digit;

    // Digits stay dark for the first GUARD_CYCLES of each slot so the
    // previous digit's segments have discharged before the next anode turns on.
    generate
        if (GUARD_CYCLES > 0) begin : g_guard
            assign guard_done = (cnt >= CNT_W'(GUARD_CYCLES));
        end else begin : g_no_guard
            assign guard_done = 1'b1;
        end
    endgenerate

    // Scan index, load buffering and frame-aligned display update.
    always_comb begin
        idx_d         = idx_q;
        disp_d        = disp_q;
        pend_d        = pend_q;
        pend_v_d      = pend_v_q;
        lz_d          = lz_en;
        frame_start_d = transfer;

        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            pend_d   = value_in;
            pend_v_d = 1'b1;
        end

        // A load in the transfer cycle itself goes straight to the display so
        // it is not deferred by a whole frame.
        if (transfer) begin
            if (load) begin
                disp_d   = value_in;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end
    end

    // Leading-zero blanking and selection of the scanned digit's nibble.
    always_comb begin
        blank       = '0;
        zeros_above = 1'b1;
        cur_nibble  = '0;
        cur_blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above & (disp_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            blank[i]    = lz_q & zeros_above;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = disp_q[i*NIBBLE_W +: NIBBLE_W];
                cur_blank  = blank[i];
            end
        end
    end

    assign digit_en    = guard_done & ~cur_blank;
    assign nibble_out  = cur_nibble;
    assign digit_sel   = NUM_DIGITS'(digit_sel_onehot(SEL_IDX_W'(idx_q), digit_en,
                                                      DIGIT_ACTIVE_LOW != 0));
    assign frame_start = frame_start_q;

    // State registers; a reset drops any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            disp_q        <= '0;
            pend_q        <= '0;
            pend_v_q      <= 1'b0;
            lz_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            lz_q          <= lz_d;
            frame_start_q <= frame_start_d;
        end
    end

endmodule
`default_nettype wire
